// File: rtl/ccip_c1_write_responder_if.sv
// ccip_c1_write_responder_if: CCI-P c1 write channel bundle between an AFU-side requester and the host model
// Ports: c1Tx (write/fence requests), c1TxAlmFull (backpressure), c1Rx (write/fence responses).
// master = requester side, slave = responder side.
// Encodings: req_type WRLINE_I=0, WRLINE_M=1, WRFENCE=4; resp_type WRLINE=1, WRFENCE=4.
interface ccip_c1_write_responder_if;
  typedef struct packed {
    logic [3:0]  req_type;
    logic [1:0]  cl_len;
    logic        sop;
    logic [15:0] mdata;
  } t_ccip_c1_req_hdr;
  typedef struct packed {
    t_ccip_c1_req_hdr hdr;
    logic             valid;
  } t_if_ccip_c1_Tx;
  typedef struct packed {
    logic [1:0]  vc_used;
    logic        hit_miss;
    logic        format;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_rsp_hdr;
  typedef struct packed {
    t_ccip_c1_rsp_hdr hdr;
    logic             rspValid;
  } t_if_ccip_c1_Rx;
  t_if_ccip_c1_Tx c1Tx;
  logic           c1TxAlmFull;
  t_if_ccip_c1_Rx c1Rx;
  modport master (output c1Tx, input c1TxAlmFull, input c1Rx);
  modport slave (input c1Tx, output c1TxAlmFull, output c1Rx);
endinterface

// File: rtl/ccip_c1_write_responder.sv
// ccip_c1_write_responder: host model answering c1 writes/fences after a programmable latency
// Ports: clk, reset (sync, active-high); bus.slave carries c1Tx in, c1TxAlmFull and c1Rx out (registered);
// error[0] sticky SOP/phase violation, error[1] sticky response-FIFO overflow.
module ccip_c1_write_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int ALMOST_FULL_THRESHOLD = 4,
  parameter int RSP_LATENCY = 4,
  parameter bit PACK_RESPONSES = 1'b1
) (
  input  logic clk,
  input  logic reset,
  ccip_c1_write_responder_if.slave bus,
  output logic [1:0] error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] E_REQ_WRLINE_I = 4'h0;
  localparam logic [3:0] E_REQ_WRLINE_M = 4'h1;
  localparam logic [3:0] E_REQ_WRFENCE = 4'h4;
  localparam logic [3:0] E_RSP_WRLINE = 4'h1;
  localparam logic [3:0] E_RSP_WRFENCE = 4'h4;
  // the output register adds one cycle, so the head leaves one cycle early
  localparam logic [7:0] LAT_M1 = 8'(RSP_LATENCY - 1);
  typedef struct packed {
    logic [3:0]  resp_type;
    logic        format;
    logic [1:0]  cl_num;
    logic [15:0] mdata;
    logic [7:0]  enq_time;
  } entry_t;
  entry_t mem [FIFO_DEPTH];
  entry_t head, ent;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nxt;
  logic [7:0] now, age;
  logic [1:0] beat_num, len_q, cur_len;
  logic [15:0] mdata_q, cur_mdata;
  logic wr_beat, fence, first, sop_err, beat_ok, last, push, pop, full, do_push;
  always_comb begin
    wr_beat = bus.c1Tx.valid && (bus.c1Tx.hdr.req_type == E_REQ_WRLINE_I || bus.c1Tx.hdr.req_type == E_REQ_WRLINE_M);
    fence = bus.c1Tx.valid && bus.c1Tx.hdr.req_type == E_REQ_WRFENCE;
    first = beat_num == 2'd0;
    // later beats of a packet use the header captured on the first beat
    cur_len = first ? bus.c1Tx.hdr.cl_len : len_q;
    cur_mdata = first ? bus.c1Tx.hdr.mdata : mdata_q;
    sop_err = wr_beat && (bus.c1Tx.hdr.sop != first);
    beat_ok = wr_beat && !sop_err;
    last = beat_num == cur_len;
    push = fence || (beat_ok && (!PACK_RESPONSES || last));
    ent.resp_type = fence ? E_RSP_WRFENCE : E_RSP_WRLINE;
    ent.format = !fence && PACK_RESPONSES;
    ent.cl_num = fence ? 2'd0 : PACK_RESPONSES ? cur_len : beat_num;
    ent.mdata = fence ? bus.c1Tx.hdr.mdata : cur_mdata;
    ent.enq_time = now;
    head = mem[rd_ptr];
    // modular age stays correct across the counter wrap
    age = now - head.enq_time;
    full = count == (AW+1)'(FIFO_DEPTH);
    pop = count != '0 && age >= LAT_M1;
    do_push = push && (!full || pop);
    count_nxt = count + (AW+1)'(do_push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ent;
    if (beat_ok && first) begin
      len_q <= bus.c1Tx.hdr.cl_len;
      mdata_q <= bus.c1Tx.hdr.mdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_num <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      now <= '0;
      error <= '0;
      bus.c1TxAlmFull <= 1'b1;
      bus.c1Rx <= '0;
    end else begin
      now <= now + 8'd1;
      if (sop_err || fence) beat_num <= '0;
      else if (beat_ok) beat_num <= last ? 2'd0 : beat_num + 2'd1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      error <= error | {push && full && !pop, sop_err || (fence && !first)};
      bus.c1TxAlmFull <= count_nxt >= (AW+1)'(FIFO_DEPTH - ALMOST_FULL_THRESHOLD);
      bus.c1Rx <= '0;
      if (pop) begin
        bus.c1Rx.rspValid <= 1'b1;
        bus.c1Rx.hdr.resp_type <= head.resp_type;
        bus.c1Rx.hdr.format <= head.format;
        bus.c1Rx.hdr.cl_num <= head.cl_num;
        bus.c1Rx.hdr.mdata <= head.mdata;
      end
    end
  end
endmodule

// File: tb/tb_ccip_c1_write_responder.sv
// tb_ccip_c1_write_responder: scoreboard bench driving three responder configurations with one stimulus stream
module tb_ccip_c1_write_responder;
  localparam int N = 3;
  localparam int DEPTH = 16;
  localparam int THR = 4;
  typedef struct packed {
    logic [26:0] v;
    int c;
  } exp_t;
  logic clk = 1'b1;
  logic rst;
  logic [23:0] tx;
  logic [26:0] rx [N];
  logic alm [N];
  logic [1:0] err [N];
  always #5 clk = ~clk;
  ccip_c1_write_responder_if b0 ();
  ccip_c1_write_responder_if b1 ();
  ccip_c1_write_responder_if b2 ();
  assign b0.c1Tx = tx;
  assign b1.c1Tx = tx;
  assign b2.c1Tx = tx;
  assign rx[0] = b0.c1Rx;
  assign rx[1] = b1.c1Rx;
  assign rx[2] = b2.c1Rx;
  assign alm[0] = b0.c1TxAlmFull;
  assign alm[1] = b1.c1TxAlmFull;
  assign alm[2] = b2.c1TxAlmFull;
  ccip_c1_write_responder #(.FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(THR), .RSP_LATENCY(4), .PACK_RESPONSES(1'b1))
    d0 (.clk(clk), .reset(rst), .bus(b0), .error(err[0]));
  ccip_c1_write_responder #(.FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(THR), .RSP_LATENCY(4), .PACK_RESPONSES(1'b0))
    d1 (.clk(clk), .reset(rst), .bus(b1), .error(err[1]));
  ccip_c1_write_responder #(.FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(THR), .RSP_LATENCY(20), .PACK_RESPONSES(1'b1))
    d2 (.clk(clk), .reset(rst), .bus(b2), .error(err[2]));
  function automatic logic pk(int i);
    return i != 1;
  endfunction
  function automatic int lt(int i);
    return i == 2 ? 20 : 4;
  endfunction
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb [N][$];
  int live [N][$];
  int last_rsp [N];
  logic [1:0] err_pend [N];
  logic [1:0] err_exp [N];
  logic alm_exp [N];
  logic prev_rst = 1'b1;
  logic [1:0] bn = 2'd0;
  logic [1:0] cap_len = 2'd0;
  logic [15:0] cap_md = 16'd0;
  task automatic chk(input string name, input int i, input logic [26:0] act, input logic [26:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, i, cyc, act, exp);
    end
  endtask
  // responses leave in order, no earlier than accept+latency and one per cycle after the previous
  task automatic push(input int i, input logic [26:0] v);
    int r;
    logic pop_now;
    pop_now = live[i].size() > 0 && live[i][0] == cyc + 1;
    if (live[i].size() == DEPTH && !pop_now) err_pend[i][1] = 1'b1;
    else begin
      r = cyc + lt(i);
      if (last_rsp[i] + 1 > r) r = last_rsp[i] + 1;
      last_rsp[i] = r;
      live[i].push_back(r);
      sb[i].push_back('{v, r});
    end
  endtask
  task automatic step(input logic r, input logic [23:0] t);
    logic [3:0] ty;
    logic [1:0] len;
    logic sop, last;
    logic [15:0] md;
    rst = r;
    tx = t;
    ty = t[23:20];
    len = t[19:18];
    sop = t[17];
    md = t[16:1];
    for (int i = 0; i < N; i++) begin
      err_exp[i] = err_pend[i];
      while (live[i].size() > 0 && live[i][0] <= cyc) void'(live[i].pop_front());
      alm_exp[i] = prev_rst || live[i].size() >= DEPTH - THR;
    end
    if (r) begin
      bn = 2'd0;
      for (int i = 0; i < N; i++) begin
        live[i].delete();
        last_rsp[i] = 0;
        err_pend[i] = 2'b00;
        while (sb[i].size() > 0 && sb[i][sb[i].size()-1].c > cyc) void'(sb[i].pop_back());
      end
    end else if (t[0] && (ty == 4'h0 || ty == 4'h1)) begin
      if (sop != (bn == 2'd0)) begin
        for (int i = 0; i < N; i++) err_pend[i][0] = 1'b1;
        bn = 2'd0;
      end else begin
        if (bn == 2'd0) begin
          cap_len = len;
          cap_md = md;
        end
        last = bn == cap_len;
        for (int i = 0; i < N; i++)
          if (!pk(i) || last) push(i, {3'b000, pk(i), pk(i) ? cap_len : bn, 4'h1, cap_md, 1'b1});
        bn = last ? 2'd0 : bn + 2'd1;
      end
    end else if (t[0] && ty == 4'h4) begin
      if (bn != 2'd0) for (int i = 0; i < N; i++) err_pend[i][0] = 1'b1;
      bn = 2'd0;
      for (int i = 0; i < N; i++) push(i, {3'b000, 1'b0, 2'b00, 4'h4, md, 1'b1});
    end
    prev_rst = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic req(input logic [3:0] ty, input logic [1:0] len, input logic sop, input logic [15:0] md);
    step(1'b0, {ty, len, sop, md, 1'b1});
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 24'd0);
  endtask
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (cyc > 0) for (int i = 0; i < N; i++) begin
      chk("almfull", i, 27'(alm[i]), 27'(alm_exp[i]));
      chk("error", i, 27'(err[i]), 27'(err_exp[i]));
      if (rx[i][0]) begin
        if (sb[i].size() == 0) chk("spurious_rsp", i, rx[i], 27'd0);
        else begin
          e = sb[i].pop_front();
          chk("rsp", i, rx[i], e.v);
          chk("rsp_cycle", i, 27'(cyc), 27'(e.c));
        end
      end else begin
        chk("idle_rx", i, rx[i], 27'd0);
        if (sb[i].size() > 0 && sb[i][0].c <= cyc) begin
          e = sb[i].pop_front();
          chk("missing_rsp", i, rx[i], e.v);
        end
      end
    end
  end
  initial begin
    logic [3:0] ty;
    logic [1:0] len;
    int k;
    for (int i = 0; i < N; i++) begin
      err_pend[i] = 2'b00;
      last_rsp[i] = 0;
    end
    for (int n = 0; n < 3; n++) step(1'b1, 24'd0);
    while (cyc < 10) idle(1);
    req(4'h0, 2'd0, 1'b1, 16'h1234);
    idle(8);
    req(4'h1, 2'd3, 1'b1, 16'h0055);
    for (int n = 0; n < 3; n++) req(4'h1, 2'($urandom), 1'b0, 16'($urandom));
    idle(10);
    req(4'h0, 2'd1, 1'b1, 16'h0a0a);
    req(4'h0, 2'd1, 1'b1, 16'h0b0b);
    req(4'h0, 2'd0, 1'b1, 16'h0c0c);
    idle(8);
    req(4'h0, 2'd0, 1'b1, 16'h0101);
    req(4'h4, 2'd0, 1'b0, 16'h0007);
    req(4'h0, 2'd0, 1'b1, 16'h0202);
    idle(8);
    for (int n = 0; n < 17; n++) req(4'h0, 2'd0, 1'b1, 16'h1000 + 16'(n));
    idle(60);
    for (int n = 0; n < 5; n++) req(4'h1, 2'd0, 1'b1, 16'h2000 + 16'(n));
    req(4'h0, 2'd3, 1'b1, 16'h2100);
    step(1'b1, {4'h0, 2'd3, 1'b0, 16'h2101, 1'b1});
    step(1'b1, 24'd0);
    idle(1);
    req(4'h0, 2'd1, 1'b1, 16'h3333);
    req(4'h0, 2'd1, 1'b0, 16'h3334);
    idle(30);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(1'b1, 24'($urandom));
        step(1'b1, 24'd0);
      end else begin
        k = $urandom_range(0, 9);
        ty = k < 4 ? 4'h0 : k < 7 ? 4'h1 : k < 8 ? 4'h4 : k == 8 ? 4'h2 : 4'h6;
        k = $urandom_range(0, 2);
        len = k == 2 ? 2'd3 : 2'(k);
        step(1'b0, {ty, len, (bn == 2'd0) ^ ($urandom_range(0, 19) == 0), 16'($urandom), $urandom_range(0, 99) < 45});
      end
    end
    idle(60);
    for (int i = 0; i < N; i++) chk("leftover", i, 27'(sb[i].size()), 27'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
